parity_fifo: RTL and testbench
==============================

PARITY_FIFO -- requirements
Module: parity_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8, 8..128).
REQ-002 SHALL have parameter DEPTH, default 512, storage depth in words (power of 2, 4..4096).
REQ-003 SHALL have parameter AF_OFFSET, default 128, almost-full threshold in words below full.
REQ-004 SHALL have parameter AE_OFFSET, default 10, almost-empty threshold in words.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-007 SHALL have port din  in  DATA_W  write data.
REQ-008 SHALL have port wren  in  1  write request.
REQ-009 SHALL have port inj_err  in  1  when high with an accepted write, the stored parity bit 0 is inverted (fault injection).
REQ-010 SHALL have port rden  in  1  read request.
REQ-011 SHALL have port dout  out  DATA_W  read data.
REQ-012 SHALL have port dout_valid  out  1  one-cycle pulse, dout updated this cycle.
REQ-013 SHALL have port par_err  out  1  parity mismatch on the word currently in dout, valid with dout_valid.
REQ-014 SHALL have port err_cnt  out  16  saturating count of parity errors.
REQ-015 SHALL have ports full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-016 SHALL have port count  out  clog2(DEPTH)+1  occupancy in words.
REQ-017 SHALL have ports wrerr, rderr  out  1 each  one-cycle overflow/underflow pulses.

Function
REQ-018 SHALL store per word DATA_W/8 parity bits, bit i = XOR of din[8i+7:8i] (even parity), alongside the data.
REQ-019 SHALL accept a write when wren=1 and full=0, evaluated against flags at the start of the cycle.
REQ-020 SHALL accept a read when rden=1 and empty=0, evaluated against flags at the start of the cycle.
REQ-021 SHALL drive dout with the head word and dout_valid=1 exactly one cycle after an accepted read; dout holds otherwise.
REQ-022 SHALL set par_err, registered with dout, when recomputed parity of the read data differs from the stored parity; par_err=0 when dout_valid=0.
REQ-023 SHALL increment err_cnt by 1 on each par_err=1 cycle, saturating at 0xFFFF.
REQ-024 SHALL pulse wrerr for one cycle the cycle after a rejected write (wren=1, full=1), with no state change.
REQ-025 SHALL pulse rderr for one cycle the cycle after a rejected read (rden=1, empty=1); dout and dout_valid unaffected.
REQ-026 SHALL update count registered: +1 write only, -1 read only, unchanged for both-accepted or neither.
REQ-027 SHALL, when empty with wren=rden=1, accept only the write and flag rderr; when full, accept only the read and flag wrerr.
REQ-028 SHALL derive flags from the registered count: full = count==DEPTH, empty = count==0, almost_full = count>=DEPTH-AF_OFFSET, almost_empty = count<=AE_OFFSET.
REQ-029 SHALL wrap read and write pointers from DEPTH-1 to 0, preserving strict FIFO order.

Reset
REQ-030 SHALL, on rst low, asynchronously clear pointers, count, dout, dout_valid, par_err, err_cnt, wrerr, rderr and almost_full/full to 0, and set empty and almost_empty to 1.
REQ-031 SHALL discard all stored contents on reset asserted mid-operation; memory array itself is not reset.
REQ-032 SHALL ignore wren/rden while rst is low and accept operations from the first rising edge after deassertion.

Structure
REQ-033 SHALL place the byte-parity function and the count-width constant helper in shared package parity_fifo_pkg.
REQ-034 SHALL implement storage as sub-module parity_fifo_ram: simple dual-port, one write port, one registered read port, width DATA_W+DATA_W/8.

Verification (DATA_W=32, DEPTH=16, AF_OFFSET=4, AE_OFFSET=2)
REQ-035 SHALL cover: write 0x01020304, then read -> dout=0x01020304, dout_valid=1 one cycle after rden, par_err=0, count 1->0.
REQ-036 SHALL cover: 16 writes -> almost_full at count 12, full at 16; 17th write -> wrerr pulse, count stays 16.
REQ-037 SHALL cover: rden on empty FIFO -> rderr pulse, dout_valid=0, dout unchanged.
REQ-038 SHALL cover: write 0xDEADBEEF with inj_err=1, read -> par_err=1 with dout=0xDEADBEEF, err_cnt=1.
REQ-039 SHALL cover: simultaneous wren/rden at count 5 for 40 cycles with incrementing data -> count stays 5, pointers wrap, read data in order.
REQ-040 SHALL cover: rst low at count 7 mid-cycle -> count=0, empty=1 immediately; after release, first write/read returns the new word.

Source files
------------

// File: rtl/parity_fifo_pkg.sv
// Shared helpers for the parity FIFO.
//   count_w     : width of an occupancy counter able to hold 0..depth inclusive
//   byte_parity : even parity (XOR reduction) of one byte
package parity_fifo_pkg;

  localparam int unsigned ErrCntW = 16;

  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/parity_fifo_ram.sv
// Simple dual-port storage for the parity FIFO.
//   clk, rst        : clock, async active-low reset (read register only)
//   we/waddr/wdata  : write port
//   re/raddr/rdata  : registered read port; rdata holds when re is low
// The array itself is never reset; only the output register is cleared.
module parity_fifo_ram #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/parity_fifo.sv
// Synchronous FIFO storing per-byte even parity alongside each word.
//   clk, rst                 : clock, async active-low reset
//   din, wren, inj_err       : write side; inj_err flips stored parity bit 0
//   rden                     : read request
//   dout, dout_valid         : read data, valid one cycle after an accepted read
//   par_err, err_cnt         : parity mismatch on dout, saturating error count
//   full, empty, almost_*    : status flags decoded from count
//   count                    : occupancy in words
//   wrerr, rderr             : overflow / underflow pulses
module parity_fifo
  import parity_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned AF_OFFSET = 128,
  parameter int unsigned AE_OFFSET = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         din,
  input  logic                      wren,
  input  logic                      inj_err,
  input  logic                      rden,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  output logic                      par_err,
  output logic [ErrCntW-1:0]        err_cnt,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      wrerr,
  output logic                      rderr
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_w(DEPTH);
  localparam int unsigned MW = DATA_W + NB;

  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               dout_valid_q, wrerr_q, rderr_q;
  logic [ErrCntW-1:0] err_cnt_q;
  logic               wr_ok, rd_ok;
  logic [NB-1:0]      wr_par, rd_par;
  logic [MW-1:0]      mem_rdata;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(DEPTH - AF_OFFSET));
  assign almost_empty = (count_q <= CW'(AE_OFFSET));

  assign wr_ok = wren & ~full;
  assign rd_ok = rden & ~empty;

  always_comb begin
    for (int i = 0; i < int'(NB); i++) begin
      wr_par[i] = byte_parity(din[8*i +: 8]);
      rd_par[i] = byte_parity(mem_rdata[8*i +: 8]);
    end
    wr_par[0] = wr_par[0] ^ inj_err;
  end

  parity_fifo_ram #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata ({wr_par, din}),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // The RAM read register doubles as the dout register, so par_err is a
  // pure function of registered state and tracks dout exactly.
  assign dout       = mem_rdata[DATA_W-1:0];
  assign par_err    = dout_valid_q & (rd_par != mem_rdata[MW-1:DATA_W]);
  assign dout_valid = dout_valid_q;
  assign err_cnt    = err_cnt_q;
  assign count      = count_q;
  assign wrerr      = wrerr_q;
  assign rderr      = rderr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      wrerr_q      <= 1'b0;
      rderr_q      <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      dout_valid_q <= rd_ok;
      wrerr_q      <= wren & full;
      rderr_q      <= rden & empty;
      if (par_err && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ErrCntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_fifo.sv
module tb_parity_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF_OFF = 4;
  localparam int unsigned AE_OFF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        wren, inj_err, rden;
  logic [31:0] dout;
  logic        dout_valid, par_err;
  logic [15:0] err_cnt;
  logic        full, empty, almost_full, almost_empty;
  logic [4:0]  count;
  logic        wrerr, rderr;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of words with a "corrupted" tag per word.
  logic [31:0] mq_data[$];
  bit          mq_bad[$];
  logic [31:0] exp_dout;
  bit          exp_valid, exp_perr, exp_wrerr, exp_rderr;
  int          exp_err;

  parity_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_OFFSET (AF_OFF),
    .AE_OFFSET (AE_OFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wren         (wren),
    .inj_err      (inj_err),
    .rden         (rden),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .par_err      (par_err),
    .err_cnt      (err_cnt),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .wrerr        (wrerr),
    .rderr        (rderr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_data.delete();
    mq_bad.delete();
    exp_dout  = '0;
    exp_valid = 0;
    exp_perr  = 0;
    exp_wrerr = 0;
    exp_rderr = 0;
    exp_err   = 0;
  endtask

  task automatic check_all();
    int n;
    n = mq_data.size();
    check_eq("count", 32'(count), 32'(n));
    check_eq("flags", {28'd0, full, empty, almost_full, almost_empty},
             {28'd0, n == int'(DEPTH), n == 0, n >= int'(DEPTH - AF_OFF), n <= int'(AE_OFF)});
    check_eq("dout", dout, exp_dout);
    check_eq("dout_valid", 32'(dout_valid), 32'(exp_valid));
    check_eq("par_err", 32'(par_err), 32'(exp_perr));
    check_eq("err_cnt", 32'(err_cnt), 32'(exp_err));
    check_eq("wrerr", 32'(wrerr), 32'(exp_wrerr));
    check_eq("rderr", 32'(rderr), 32'(exp_rderr));
  endtask

  // Called just after a negedge: drive inputs, advance one clock, check.
  task automatic step(input bit w, input bit inj, input bit r, input logic [31:0] d);
    bit is_full, is_empty, acc_w, acc_r;
    wren = w; inj_err = inj; rden = r; din = d;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      is_full  = (mq_data.size() == int'(DEPTH));
      is_empty = (mq_data.size() == 0);
      acc_w = w && !is_full;
      acc_r = r && !is_empty;
      exp_wrerr = w && is_full;
      exp_rderr = r && is_empty;
      if (exp_perr && exp_err < 32'hFFFF) exp_err++;
      if (acc_r) begin
        exp_dout  = mq_data.pop_front();
        exp_perr  = mq_bad.pop_front();
        exp_valid = 1;
      end else begin
        exp_valid = 0;
        exp_perr  = 0;
      end
      if (acc_w) begin
        mq_data.push_back(d);
        mq_bad.push_back(inj);
      end
    end
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] seq;
    rst = 1'b0; wren = 0; rden = 0; inj_err = 0; din = '0;
    model_reset();
    @(negedge clk);
    step(1, 0, 1, 32'h1234_5678);   // ignored while in reset
    rst = 1'b1;

    // Single write then read.
    step(1, 0, 0, 32'h0102_0304);
    step(0, 0, 1, 32'h0);
    check_eq("basic_dout", dout, 32'h0102_0304);
    idle();

    // Fill to full, then overflow.
    for (int i = 0; i < 17; i++) step(1, 0, 0, 32'hA000_0000 + 32'(i));
    check_eq("full_wrerr", 32'(wrerr), 32'd1);
    step(1, 0, 1, 32'hBBBB_BBBB);   // full: only the read is accepted
    for (int i = 0; i < 17; i++) step(0, 0, 1, 32'h0);

    // Underflow and empty with both requests.
    step(0, 0, 1, 32'h0);
    step(1, 0, 1, 32'hCAFE_0001);
    step(0, 0, 1, 32'h0);

    // Injected parity error.
    step(1, 1, 0, 32'hDEAD_BEEF);
    step(0, 0, 1, 32'h0);
    check_eq("inj_par_err", 32'(par_err), 32'd1);
    idle();
    check_eq("inj_err_cnt", 32'(err_cnt), 32'd1);

    // Steady state at count 5 with wrapping pointers.
    seq = 32'h100;
    for (int i = 0; i < 5; i++) begin step(1, 0, 0, seq); seq++; end
    for (int i = 0; i < 40; i++) begin step(1, 0, 1, seq); seq++; end
    check_eq("steady_count", 32'(count), 32'd5);
    for (int i = 0; i < 2; i++) begin step(1, 0, 0, seq); seq++; end

    // Asynchronous reset mid-cycle at count 7.
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    step(1, 0, 1, 32'h5555_5555);
    rst = 1'b1;
    step(1, 0, 0, 32'h7777_0001);
    step(0, 0, 1, 32'h0);
    check_eq("post_reset_dout", dout, 32'h7777_0001);

    // Randomized traffic with fill-biased and drain-biased phases.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 60; i++) begin
        step(($urandom_range(0, 9) < ((ph % 2 == 0) ? 7 : 3)),
             ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 9) < ((ph % 2 == 0) ? 3 : 7)),
             $urandom);
      end
    end
    for (int i = 0; i < 20; i++) step(0, 0, 1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
